code_bank: RTL and testbench
============================

Name: code_bank

Overview:
- Parametrised successor to the two-output select/enable counter (Output0 counts every cycle, Output1 counts every 4th cycle).
- Generalised to CHANNELS independent counters of WIDTH bits. Each channel has its own prescale ratio.
- Adds up/down direction, wrap-or-saturate mode, synchronous load and per-channel terminal-count pulses.
- Sits as a free-standing event/time-base counter bank, driven by a single select and enable.

Parameters:
- WIDTH, 64, counter width per channel (>=2).
- CHANNELS, 4, number of counters (>=2).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS.
- DIV_SHIFT, 2, channel k prescale ratio is 2**(DIV_SHIFT*k), so ratios are 1,4,16,64 by default (DIV_SHIFT*(CHANNELS-1) <= 16).
- SATURATE, 0, 0 = wrap at terminal count, 1 = hold at terminal count.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous active-low reset (Reset=0 at a Clk edge resets).
- Slt  in  SEL_W  selects the channel acted on this cycle; values >= CHANNELS select nothing.
- En  in  1  advance the selected channel.
- Dn  in  1  direction for the selected channel: 0 = up, 1 = down.
- Ld  in  1  load LdVal into the selected channel.
- LdVal  in  WIDTH  load value.
- Output  out  CHANNELS*WIDTH  channel k count at bits [k*WIDTH +: WIDTH], registered.
- Tc  out  CHANNELS  one-cycle pulse per channel on a terminal-count step, registered.

Behaviour:
- Reset (Reset=0): all counts 0, all prescalers 0, Tc=0. Reset overrides Ld and En.
- Each channel holds a prescaler PRE_k of 16 bits. Channel 0 has no prescaler, ratio 1.
- Priority for the selected channel s each edge: Reset > Ld > En.
- Ld=1:
  - count_s <= LdVal; PRE_s <= 0; Tc_s <= 0.
  - En is ignored that cycle.
- En=1, Ld=0:
  - If PRE_s == ratio_s-1: PRE_s <= 0 and count_s steps.
  - Otherwise PRE_s increments and the count holds.
- Step up:
  - count != all-ones: count+1.
  - At all-ones with SATURATE=0: wraps to 0, Tc_s=1.
  - At all-ones with SATURATE=1: holds, Tc_s=1.
- Step down:
  - count != 0: count-1.
  - At 0 with SATURATE=0: wraps to all-ones, Tc_s=1.
  - At 0 with SATURATE=1: holds at 0, Tc_s=1.
- Tc is high only in the cycle after the terminal step. Saturated channels pulse Tc again on every further step attempt.
- Unselected channels, or En=0: count and PRE hold; Tc clears to 0.
- Dn changing mid-prescale does not reset PRE; direction is sampled at the step edge.
- Latency:
  - Output reflects a step or load one edge after the qualifying cycle.
  - Tc asserts in the same cycle the stepped value appears.
- Slt out of range: no channel changes; all Tc clear.
- Reset mid-prescale discards the partial PRE count.
- Arithmetic is unsigned modulo 2**WIDTH.

Decomposition:
- Shared package holds:
  - direction constants DIR_UP=0, DIR_DN=1;
  - mode constants MODE_WRAP=0, MODE_SAT=1;
  - a function ratio(k) returning 2**(DIV_SHIFT*k).
- Sub-module code_chan: one counter plus prescaler, with parameters WIDTH, RATIO, SATURATE and inputs sel_en, ld, dn, ldval.
- Top code_bank does the Slt decode, a generate loop over code_chan, and output packing.

Test Plan:
- Reset low 1 cycle, then Slt=0, En=1 for 10 cycles -> Output[63:0]=10, all other channels 0, Tc=0.
- Slt=1, En=1 for 12 cycles from 0 -> channel 1 reads 1,2,3 after cycles 4,8,12; channel 0 unchanged; switching to Slt=0 after 2 cycles then back keeps PRE_1=2.
- SATURATE=0, Ld=1 LdVal=64'hFFFF_FFFF_FFFF_FFFF on ch0, then En=1 -> ch0=0 with Tc[0]=1 for exactly 1 cycle. SATURATE=1 variant: ch0 holds all-ones and Tc[0] pulses on every step.
- ch0=0, Dn=1, En=1 -> ch0=64'hFFFF_FFFF_FFFF_FFFF, Tc[0]=1 (wrap build); ch0 stays 0 with Tc[0]=1 (saturate build).
- Ld=1 and En=1 together on ch2 with LdVal=5 -> ch2=5, PRE_2=0; 16 further En cycles -> ch2=6.
- Reset=0 asserted while ch3 PRE=40 and ch3=7 -> next cycle all outputs 0; Slt=4 (out of range) with En=1 -> no change.

Source files
------------

// File: rtl/code_bank_pkg.sv
// Shared constants and helpers for the code_bank counter bank.
package code_bank_pkg;

    // Counting direction as seen on Dn.
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Terminal-count behaviour.
    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Every prescaler is this wide, so ratios up to 2**16 are supported.
    localparam int PRE_W = 16;

    localparam int DIV_SHIFT_DEF = 2;

    // Prescale ratio of channel k: 2**(div_shift*k).
    function automatic int ratio(input int k, input int div_shift = DIV_SHIFT_DEF);
        return 1 << (div_shift * k);
    endfunction

endpackage

// File: rtl/code_bank_chan.sv
// One counter channel: prescaler, up/down counter, wrap-or-saturate, terminal-count pulse.
module code_chan
    import code_bank_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int RATIO    = 1,
    parameter bit SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_en,
    input  logic             ld,
    input  logic             dn,
    input  logic [WIDTH-1:0] ldval,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // The step edge is the one where the prescaler has already seen RATIO-1 enables.
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(RATIO - 1);

    logic [PRE_W-1:0] pre;

    // Load / prescale / step, with Tc as a one-cycle registered pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            pre   <= '0;
            tc    <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here; the Tc default below is then
            // cleanly overridden by a later assignment in the same edge.
            tc <= 1'b0;
            if (ld) begin
                count <= ldval;
                pre   <= '0;
            end else if (sel_en) begin
                if (pre == PRE_MAX) begin
                    pre <= '0;
                    // Direction is sampled only here, so a change mid-prescale is harmless.
                    if (dn == DIR_DN) begin
                        if (count == '0) begin
                            tc <= 1'b1;
                            if (SATURATE == MODE_WRAP) count <= '1;
                        end else begin
                            count <= count - WIDTH'(1);
                        end
                    end else begin
                        if (count == '1) begin
                            tc <= 1'b1;
                            if (SATURATE == MODE_WRAP) count <= '0;
                        end else begin
                            count <= count + WIDTH'(1);
                        end
                    end
                end else begin
                    pre <= pre + PRE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/code_bank.sv
// Bank of CHANNELS prescaled up/down counters driven by one select and enable.
module code_bank
    import code_bank_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int CHANNELS  = 4,
    parameter int SEL_W     = 2,
    parameter int DIV_SHIFT = 2,
    parameter bit SATURATE  = MODE_WRAP
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [SEL_W-1:0]          Slt,
    input  logic                      En,
    input  logic                      Dn,
    input  logic                      Ld,
    input  logic [WIDTH-1:0]          LdVal,
    output logic [CHANNELS*WIDTH-1:0] Output,
    output logic [CHANNELS-1:0]       Tc
);

    // One channel per select value; out-of-range selects match no channel.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        logic             sel;
        logic [WIDTH-1:0] count;
        logic             tc;

        assign sel = (Slt == SEL_W'(k));

        code_chan #(
            .WIDTH   (WIDTH),
            .RATIO   (ratio(k, DIV_SHIFT)),
            .SATURATE(SATURATE)
        ) u_chan (
            .clk   (Clk),
            .rst_n (Reset),
            .sel_en(sel & En),
            .ld    (sel & Ld),
            .dn    (Dn),
            .ldval (LdVal),
            .count (count),
            .tc    (tc)
        );

        assign Output[k*WIDTH +: WIDTH] = count;
        assign Tc[k]                    = tc;
    end

endmodule

// File: tb/tb_code_bank.sv
// Directed bench for code_bank: a wrapping bank and a saturating bank share stimulus.
module tb_code_bank;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   slt = 3'd0;
    logic         en  = 1'b0;
    logic         dn  = 1'b0;
    logic         ld  = 1'b0;
    logic [63:0]  ldval = 64'd0;

    logic         en_w, ld_w;
    logic [255:0] out_w, out_s;
    logic [3:0]   tc_w, tc_s;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // The wrap bank has a 2-bit select; selects >= 4 must look like "nothing" to it.
    assign en_w = en & ~slt[2];
    assign ld_w = ld & ~slt[2];

    code_bank #(.WIDTH(64), .CHANNELS(4), .SEL_W(2), .DIV_SHIFT(2), .SATURATE(1'b0)) dut_w (
        .Clk(clk), .Reset(rst), .Slt(slt[1:0]), .En(en_w), .Dn(dn), .Ld(ld_w),
        .LdVal(ldval), .Output(out_w), .Tc(tc_w)
    );

    code_bank #(.WIDTH(64), .CHANNELS(4), .SEL_W(3), .DIV_SHIFT(2), .SATURATE(1'b1)) dut_s (
        .Clk(clk), .Reset(rst), .Slt(slt), .En(en), .Dn(dn), .Ld(ld),
        .LdVal(ldval), .Output(out_s), .Tc(tc_s)
    );

    function automatic logic [63:0] ch(input logic [255:0] v, input int k);
        return v[k*64 +: 64];
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; ld = 1'b0; dn = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        // Reset must win over a simultaneous load and enable.
        rst = 1'b0; slt = 3'd0; en = 1'b1; ld = 1'b1; ldval = 64'd123;
        step();
        checks++; if (out_w !== '0) begin fails++; $display("FAIL reset_out_w got %h want 0", out_w); end
        checks++; if (out_s !== '0) begin fails++; $display("FAIL reset_out_s got %h want 0", out_s); end
        checks++; if (tc_w !== 4'd0 || tc_s !== 4'd0) begin fails++; $display("FAIL reset_tc got %b/%b want 0000", tc_w, tc_s); end
        rst = 1'b1; en = 1'b0; ld = 1'b0;
    endtask

    task automatic test_ch0_count();
        slt = 3'd0; en = 1'b1;
        step(10);
        en = 1'b0;
        checks++; if (ch(out_w, 0) !== 64'd10) begin fails++; $display("FAIL ch0_count got %0d want 10", ch(out_w, 0)); end
        checks++; if (out_w[255:64] !== '0) begin fails++; $display("FAIL ch0_others got %h want 0", out_w[255:64]); end
        checks++; if (ch(out_s, 0) !== 64'd10) begin fails++; $display("FAIL ch0_count_sat got %0d want 10", ch(out_s, 0)); end
        checks++; if (tc_w !== 4'd0) begin fails++; $display("FAIL ch0_tc got %b want 0000", tc_w); end
    endtask

    task automatic test_prescale();
        do_reset();
        slt = 3'd1; en = 1'b1;
        step(2);
        checks++; if (ch(out_w, 1) !== 64'd0) begin fails++; $display("FAIL pre_ch1_a got %0d want 0", ch(out_w, 1)); end
        // Detour to channel 0; channel 1 keeps its partial prescale of 2.
        slt = 3'd0;
        step(3);
        checks++; if (ch(out_w, 0) !== 64'd3) begin fails++; $display("FAIL pre_ch0 got %0d want 3", ch(out_w, 0)); end
        slt = 3'd1;
        step();
        checks++; if (ch(out_w, 1) !== 64'd0) begin fails++; $display("FAIL pre_ch1_b got %0d want 0", ch(out_w, 1)); end
        step();
        checks++; if (ch(out_w, 1) !== 64'd1) begin fails++; $display("FAIL pre_ch1_1 got %0d want 1", ch(out_w, 1)); end
        step(4);
        checks++; if (ch(out_w, 1) !== 64'd2) begin fails++; $display("FAIL pre_ch1_2 got %0d want 2", ch(out_w, 1)); end
        step(4);
        checks++; if (ch(out_w, 1) !== 64'd3) begin fails++; $display("FAIL pre_ch1_3 got %0d want 3", ch(out_w, 1)); end
        checks++; if (ch(out_s, 1) !== 64'd3) begin fails++; $display("FAIL pre_ch1_sat got %0d want 3", ch(out_s, 1)); end
        checks++; if (ch(out_w, 0) !== 64'd3) begin fails++; $display("FAIL pre_ch0_hold got %0d want 3", ch(out_w, 0)); end
        en = 1'b0;
    endtask

    task automatic test_terminal_up();
        slt = 3'd0; ld = 1'b1; ldval = ONES;
        step();
        ld = 1'b0;
        checks++; if (ch(out_w, 0) !== ONES) begin fails++; $display("FAIL up_load got %h want %h", ch(out_w, 0), ONES); end
        checks++; if (tc_w !== 4'd0) begin fails++; $display("FAIL up_load_tc got %b want 0000", tc_w); end
        en = 1'b1;
        step();
        checks++; if (ch(out_w, 0) !== 64'd0) begin fails++; $display("FAIL up_wrap got %h want 0", ch(out_w, 0)); end
        checks++; if (tc_w !== 4'b0001) begin fails++; $display("FAIL up_wrap_tc got %b want 0001", tc_w); end
        checks++; if (ch(out_s, 0) !== ONES) begin fails++; $display("FAIL up_sat got %h want %h", ch(out_s, 0), ONES); end
        checks++; if (tc_s !== 4'b0001) begin fails++; $display("FAIL up_sat_tc got %b want 0001", tc_s); end
        en = 1'b0;
        step();
        checks++; if (tc_w !== 4'd0 || tc_s !== 4'd0) begin fails++; $display("FAIL up_tc_clear got %b/%b want 0000", tc_w, tc_s); end
        en = 1'b1;
        step();
        checks++; if (ch(out_w, 0) !== 64'd1 || tc_w !== 4'd0) begin fails++; $display("FAIL up_after_wrap got %h/%b want 1/0000", ch(out_w, 0), tc_w); end
        checks++; if (ch(out_s, 0) !== ONES || tc_s !== 4'b0001) begin fails++; $display("FAIL up_sat_again got %h/%b want %h/0001", ch(out_s, 0), tc_s, ONES); end
        step();
        checks++; if (tc_s !== 4'b0001) begin fails++; $display("FAIL up_sat_third got %b want 0001", tc_s); end
        en = 1'b0;
    endtask

    task automatic test_terminal_down();
        slt = 3'd0; ld = 1'b1; ldval = 64'd0;
        step();
        ld = 1'b0; dn = 1'b1; en = 1'b1;
        step();
        checks++; if (ch(out_w, 0) !== ONES || tc_w !== 4'b0001) begin fails++; $display("FAIL dn_wrap got %h/%b want %h/0001", ch(out_w, 0), tc_w, ONES); end
        checks++; if (ch(out_s, 0) !== 64'd0 || tc_s !== 4'b0001) begin fails++; $display("FAIL dn_sat got %h/%b want 0/0001", ch(out_s, 0), tc_s); end
        step();
        checks++; if (ch(out_w, 0) !== 64'hFFFF_FFFF_FFFF_FFFE || tc_w !== 4'd0) begin fails++; $display("FAIL dn_after_wrap got %h/%b want fffffffffffffffe/0000", ch(out_w, 0), tc_w); end
        checks++; if (ch(out_s, 0) !== 64'd0 || tc_s !== 4'b0001) begin fails++; $display("FAIL dn_sat_again got %h/%b want 0/0001", ch(out_s, 0), tc_s); end
        en = 1'b0; dn = 1'b0;
    endtask

    task automatic test_load_en();
        slt = 3'd2; en = 1'b1;
        step(3);
        checks++; if (ch(out_w, 2) !== 64'd0) begin fails++; $display("FAIL ld_pre_partial got %0d want 0", ch(out_w, 2)); end
        // Load wins over enable and discards the partial prescale of 3.
        ld = 1'b1; ldval = 64'd5;
        step();
        ld = 1'b0;
        checks++; if (ch(out_w, 2) !== 64'd5) begin fails++; $display("FAIL ld_value got %0d want 5", ch(out_w, 2)); end
        step(15);
        checks++; if (ch(out_w, 2) !== 64'd5) begin fails++; $display("FAIL ld_15 got %0d want 5", ch(out_w, 2)); end
        step();
        checks++; if (ch(out_w, 2) !== 64'd6) begin fails++; $display("FAIL ld_16 got %0d want 6", ch(out_w, 2)); end
        checks++; if (ch(out_s, 2) !== 64'd6) begin fails++; $display("FAIL ld_16_sat got %0d want 6", ch(out_s, 2)); end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        slt = 3'd0; ld = 1'b1; ldval = 64'd9;
        step();
        slt = 3'd3; ldval = 64'd7;
        step();
        ld = 1'b0; en = 1'b1;
        step(40);
        checks++; if (ch(out_w, 3) !== 64'd7 || ch(out_w, 0) !== 64'd9) begin fails++; $display("FAIL mid_before got %0d/%0d want 7/9", ch(out_w, 3), ch(out_w, 0)); end
        rst = 1'b0;
        step();
        checks++; if (out_w !== '0 || out_s !== '0) begin fails++; $display("FAIL mid_reset got %h/%h want 0", out_w, out_s); end
        rst = 1'b1;
        step(63);
        checks++; if (ch(out_w, 3) !== 64'd0) begin fails++; $display("FAIL mid_63 got %0d want 0", ch(out_w, 3)); end
        step();
        checks++; if (ch(out_w, 3) !== 64'd1) begin fails++; $display("FAIL mid_64 got %0d want 1", ch(out_w, 3)); end
        en = 1'b0;
    endtask

    task automatic test_out_of_range();
        slt = 3'd0; ld = 1'b1; ldval = ONES;
        step();
        ld = 1'b0; en = 1'b1;
        step();
        checks++; if (tc_s !== 4'b0001 || tc_w !== 4'b0001) begin fails++; $display("FAIL oor_setup_tc got %b/%b want 0001", tc_w, tc_s); end
        slt = 3'd4; ld = 1'b1; ldval = 64'd99;
        step();
        checks++; if (out_s !== {64'd1, 64'd0, 64'd0, ONES}) begin fails++; $display("FAIL oor_out_s got %h", out_s); end
        checks++; if (out_w !== {64'd1, 64'd0, 64'd0, 64'd0}) begin fails++; $display("FAIL oor_out_w got %h", out_w); end
        checks++; if (tc_s !== 4'd0 || tc_w !== 4'd0) begin fails++; $display("FAIL oor_tc got %b/%b want 0000", tc_w, tc_s); end
        ld = 1'b0; en = 1'b0; slt = 3'd0;
    endtask

    initial begin
        step();
        test_reset();
        test_ch0_count();
        test_prescale();
        test_terminal_up();
        test_terminal_down();
        test_load_en();
        test_reset_mid();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
